pc_next_unit: RTL and testbench

- Program-counter stage directly downstream of the 32-bit shift-left-by-2 block in the MIPS datapath.
- Consumes the shifted branch offset and the shifted jump index, forms PC+4, branch, jump and jump-register targets, and holds the architectural PC register.
- Supplies the PC to instruction fetch. Honours pipeline stall.

---
 rtl/pc_next_unit_pkg.sv | 20 ++
 rtl/pc_next_unit_pc_adder.sv | 12 +
 rtl/pc_next_unit.sv | 155 +++++++++++++++
 tb/tb_pc_next_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the MIPS program-counter stage: reset vector,
// redirect-select encoding and delay-slot FSM state codes.
package pc_next_unit_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int          PC_ADDR_W            = 32;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SLOT = 1'b1
  } state_e;

endpackage

// File: rtl/pc_next_unit_pc_adder.sv
// Modulo-2^W adder; the carry out is discarded.
module pc_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/pc_next_unit.sv
// PC stage: forms PC+4, branch, jump and JR targets and holds the PC register.
// Define PC_NEXT_DELAY_SLOT_EN to enable the architectural branch delay slot.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          ADDR_W       = PC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic [ADDR_W-1:0] imm_sl2,
  input  logic [27:0]       jidx_sl2,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] branch_target,
  output logic              misalign_err,
  output logic              in_delay_slot
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_misalign;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_branch_target;
  logic [ADDR_W-1:0] w_jump_target;
  logic [ADDR_W-1:0] w_redirect_target;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_misalign_next;
  logic              w_jr_misalign;
  logic              w_redirect;
  sel_e              w_sel;

  pc_adder #(.W(ADDR_W)) u_add_seq (
    .i_a   (r_pc),
    .i_b   (ADDR_W'(4)),
    .o_sum (w_pc_plus4)
  );

  pc_adder #(.W(ADDR_W)) u_add_br (
    .i_a   (w_pc_plus4),
    .i_b   (imm_sl2),
    .o_sum (w_branch_target)
  );

  assign w_jump_target = {w_pc_plus4[ADDR_W-1:ADDR_W-4], jidx_sl2};
  assign w_jr_misalign = jump_reg & (rs_val[1:0] != 2'b00);

  // A misaligned JR kills every redirect in its cycle, not just its own.
  always_comb begin
    w_sel = SEL_SEQ;
    if (jump_reg) begin
      w_sel = SEL_JR;
    end else if (jump) begin
      w_sel = SEL_J;
    end else if (branch_taken) begin
      w_sel = SEL_BR;
    end
    w_redirect = (w_sel != SEL_SEQ) && !w_jr_misalign;
  end

  always_comb begin
    w_redirect_target = w_pc_plus4;
    case (w_sel)
      SEL_BR:  w_redirect_target = w_branch_target;
      SEL_J:   w_redirect_target = w_jump_target;
      SEL_JR:  w_redirect_target = rs_val;
      default: w_redirect_target = w_pc_plus4;
    endcase
  end

`ifdef PC_NEXT_DELAY_SLOT_EN
  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_target;
  logic [ADDR_W-1:0] w_target_next;
  logic              r_dslot;
  logic              w_dslot_next;

  // Redirects are deferred by one instruction; inputs are ignored in SLOT.
  always_comb begin
    w_state_next    = r_state;
    w_target_next   = r_target;
    w_pc_next       = r_pc;
    w_misalign_next = 1'b0;
    w_dslot_next    = r_dslot;
    if (en) begin
      case (r_state)
        ST_IDLE: begin
          w_pc_next       = w_pc_plus4;
          w_misalign_next = w_jr_misalign;
          if (w_redirect) begin
            w_target_next = w_redirect_target;
            w_dslot_next  = 1'b1;
            w_state_next  = ST_SLOT;
          end
        end
        ST_SLOT: begin
          w_pc_next    = r_target;
          w_dslot_next = 1'b0;
          w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_dslot_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_dslot  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_target <= w_target_next;
      r_dslot  <= w_dslot_next;
    end
  end

  assign in_delay_slot = r_dslot;
`else
  always_comb begin
    w_pc_next       = r_pc;
    w_misalign_next = 1'b0;
    if (en) begin
      w_pc_next       = w_redirect ? w_redirect_target : w_pc_plus4;
      w_misalign_next = w_jr_misalign;
    end
  end

  assign in_delay_slot = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_misalign <= w_misalign_next;
    end
  end

  assign pc            = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign branch_target = w_branch_target;
  assign misalign_err  = r_misalign;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: directed plan plus randomized traffic
// against a behavioural PC model. Honours PC_NEXT_DELAY_SLOT_EN.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset, en, branch_taken, jump, jump_reg;
  logic [31:0] imm_sl2, rs_val;
  logic [27:0] jidx_sl2;
  logic [31:0] pc, pc_plus4, branch_target;
  logic        misalign_err, in_delay_slot;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic        ds;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon;
  logic [31:0] mPc;
  logic [31:0] mSlotQ[$];
  int          total = 0;
  int          bad   = 0;

  pc_next_unit dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .jump_reg      (jump_reg),
    .imm_sl2       (imm_sl2),
    .jidx_sl2      (jidx_sl2),
    .rs_val        (rs_val),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .misalign_err  (misalign_err),
    .in_delay_slot (in_delay_slot)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: the next architectural state follows from the current model
  // state and this cycle's inputs; the delay slot is a queue of pending targets.
  task automatic applyStimulus(input logic r, input logic e, input logic br, input logic j,
                               input logic jr, input logic [31:0] imm, input logic [27:0] jidx,
                               input logic [31:0] rs);
    exp_t        x;
    logic [31:0] p4, tgt;
    logic        redir;
    reset = r; en = e; branch_taken = br; jump = j; jump_reg = jr;
    imm_sl2 = imm; jidx_sl2 = jidx; rs_val = rs;
    p4 = mPc + 32'd4;
    x.mis = 1'b0;
    x.ds  = (mSlotQ.size() != 0);
    if (r) begin
      mPc = 32'h0;
      mSlotQ.delete();
      x.ds = 1'b0;
    end else if (e) begin
      if (mSlotQ.size() != 0) begin
        mPc  = mSlotQ.pop_front();
        x.ds = 1'b0;
      end else begin
        redir = 1'b1;
        if (jr && rs[1:0] != 2'b00) begin
          x.mis = 1'b1;
          redir = 1'b0;
          tgt   = p4;
        end else if (jr)  tgt = rs;
        else if (j)       tgt = {p4[31:28], jidx};
        else if (br)      tgt = p4 + imm;
        else begin
          redir = 1'b0;
          tgt   = p4;
        end
`ifdef PC_NEXT_DELAY_SLOT_EN
        if (redir) begin
          mSlotQ.push_back(tgt);
          x.ds = 1'b1;
          tgt  = p4;
        end
`endif
        mPc = tgt;
      end
    end
    x.pc = mPc;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic seqStep();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 28'h0, 32'h0);
  endtask

  task automatic setPc(input logic [31:0] v);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 28'h0, v);
`ifdef PC_NEXT_DELAY_SLOT_EN
    seqStep();
`endif
  endtask

  // Monitor: every cycle presents a registered result, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon = sb.pop_front();
      checkOutput("pc", pc, mon.pc);
      checkOutput("misalign_err", {31'h0, misalign_err}, {31'h0, mon.mis});
      checkOutput("in_delay_slot", {31'h0, in_delay_slot}, {31'h0, mon.ds});
      checkOutput("pc_plus4", pc_plus4, mon.pc + 32'd4);
      checkOutput("branch_target", branch_target, mon.pc + 32'd4 + imm_sl2);
    end
  end

  initial begin
    mPc = 32'h0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 28'h10, 32'h10);
    repeat (3) seqStep();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 28'h0, 32'h0);

    setPc(32'h0000_0100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 28'h0, 32'h0);
    seqStep();

    setPc(32'h3000_0010);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 28'h0ABC_DEF0, 32'h0);
    seqStep();

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 28'h0, 32'h0000_2002);
    seqStep();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 28'h0, 32'h0000_2000);
    seqStep();

    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 28'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 28'h0, 32'h0);
    seqStep();
    seqStep();

    setPc(32'hFFFF_FFFC);
    seqStep();

    setPc(32'h0000_0040);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3C, 28'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 28'h0, 32'h0);
    seqStep();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3C, 28'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 28'h0, 32'h0);
    seqStep();

    for (int i = 0; i < 500; i++) begin
      logic [31:0] rsv;
      rsv = $urandom;
      if ($urandom_range(1, 0) == 1) rsv[1:0] = 2'b00;
      applyStimulus(($urandom_range(99, 0) < 3),
                    ($urandom_range(99, 0) < 80),
                    ($urandom_range(99, 0) < 30),
                    ($urandom_range(99, 0) < 15),
                    ($urandom_range(99, 0) < 15),
                    {$urandom_range(32'h3FFF_FFFF, 0), 2'b00} ^ (($urandom_range(1, 0) == 1) ? 32'hFFFF_0000 : 32'h0),
                    28'({$urandom_range(32'h03FF_FFFF, 0), 2'b00}),
                    rsv);
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
